// File: rtl/display_scanout.sv
// Raster timing generator and ping-pong scanout for two 100x100 RGB frame buffers.
// Pixels, syncs and de all leave one cycle after the read is issued.
module display_scanout #(
  parameter int H_ACTIVE = 100,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 100,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        disp_sel,
  output logic        re1,
  output logic        re2,
  output logic [1:0]  we_blk,
  output logic [19:0] addr,
  input  logic [7:0]  r1,
  input  logic [7:0]  g1,
  input  logic [7:0]  b1,
  input  logic [7:0]  r2,
  input  logic [7:0]  g2,
  input  logic [7:0]  b2,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          swap_pending;
  logic          sel_d;
  logic          active, h_last, frame_last, swap_now;
  logic          hsync_raw, vsync_raw, frame_start_raw;

  assign active          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign h_last          = (h_cnt == H_LAST);
  assign frame_last      = h_last && (v_cnt == V_LAST);
  assign hsync_raw       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vsync_raw       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign frame_start_raw = (h_cnt == '0) && (v_cnt == '0);

  // A request on the boundary cycle itself still makes this boundary.
  assign swap_now = frame_last && (swap_pending || swap_req);
  assign swap_ack = swap_now && !reset;

  assign re1    = active && !disp_sel;
  assign re2    = active &&  disp_sel;
  assign we_blk = {disp_sel, ~disp_sel};

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      addr         <= '0;
      disp_sel     <= 1'b0;
      swap_pending <= 1'b0;
      de           <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      sel_d        <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      if (frame_last)  addr <= '0;
      else if (active) addr <= addr + 1'b1;

      if (swap_now) begin
        disp_sel     <= ~disp_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end

      de          <= active;
      hsync       <= hsync_raw;
      vsync       <= vsync_raw;
      sel_d       <= disp_sel;
      frame_start <= frame_start_raw;
    end
  end

  // sel_d tracks the buffer the returning word was read from, not the current one.
  assign {pix_r, pix_g, pix_b} = de ? (sel_d ? {r2, g2, b2} : {r1, g1, b1}) : 24'h0;
endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: buffer models, timing table and a frame-level reference model.
module tb_display_scanout;
  localparam int HT = 120, VT = 108, FRAME = HT * VT;

  logic        clk = 1'b0, reset = 1'b1, swap_req = 1'b0;
  logic        swap_ack, disp_sel, re1, re2, hsync, vsync, de, frame_start;
  logic [1:0]  we_blk;
  logic [19:0] addr;
  logic [7:0]  r1, g1, b1, r2, g2, b2, pix_r, pix_g, pix_b;
  logic [23:0] rd1 = '0, rd2 = '0;
  logic [23:0] mem1 [10000];
  logic [23:0] mem2 [10000];

  int checks = 0, failures = 0;

  display_scanout dut (
    .clk(clk), .reset(reset), .swap_req(swap_req), .swap_ack(swap_ack),
    .disp_sel(disp_sel), .re1(re1), .re2(re2), .we_blk(we_blk), .addr(addr),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffers with a 1-cycle registered read.
  always @(posedge clk) begin
    if (re1) rd1 <= mem1[addr];
    if (re2) rd2 <= mem2[addr];
  end
  assign {r1, g1, b1} = rd1;
  assign {r2, g2, b2} = rd2;

  typedef struct {
    int          t;
    bit          chk_addr;
    logic [19:0] addr;
    bit          de, hs, vs, fs;
  } vec_t;
  vec_t tbl[$];

  // Reference model state: cycle index within the frame, displayed buffer,
  // whether a request has arrived since the last boundary, and last cycle's raw outputs.
  int          t, frame, de_cnt, ack_cnt;
  bit          sel, seen, p_act, p_hs, p_vs, p_fs;
  logic [23:0] p_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s frame=%0d t=%0d actual=%0h required=%0h", name, frame, t, act, exp);
    end
  endtask

  task automatic model_init();
    t = 0; sel = 0; seen = 0;
    p_act = 0; p_hs = 0; p_vs = 0; p_fs = 0; p_word = '0;
  endtask

  // Entered one unit after a rising edge; checks the current cycle, then advances.
  task automatic cycle(input bit req);
    int h, v;
    bit act, last, ack;
    logic [19:0] a;
    swap_req = req;
    #1;
    h = t % HT; v = t / HT;
    act  = (h < 100) && (v < 100);
    last = (t == FRAME - 1);
    a    = 20'(v * 100 + h);
    ack  = last && (seen || req);

    chk("re1", re1, act && !sel);
    chk("re2", re2, act && sel);
    chk("disp_sel", disp_sel, sel);
    chk("we_blk", we_blk, sel ? 2'b10 : 2'b01);
    if (act) chk("addr", addr, a);
    chk("swap_ack", swap_ack, ack);
    chk("de", de, p_act);
    chk("hsync", hsync, p_hs);
    chk("vsync", vsync, p_vs);
    chk("frame_start", frame_start, p_fs);
    chk("pix", {pix_r, pix_g, pix_b}, p_act ? p_word : 24'h0);

    if (frame == 0)
      foreach (tbl[i])
        if (tbl[i].t == t) begin
          chk("tbl_de", de, tbl[i].de);
          chk("tbl_hsync", hsync, tbl[i].hs);
          chk("tbl_vsync", vsync, tbl[i].vs);
          chk("tbl_fstart", frame_start, tbl[i].fs);
          if (tbl[i].chk_addr) chk("tbl_addr", addr, tbl[i].addr);
        end

    if (de) de_cnt++;
    if (swap_ack) ack_cnt++;

    p_act  = act;
    p_word = act ? (sel ? mem2[a] : mem1[a]) : 24'h0;
    p_hs   = (h >= 104) && (h < 112);
    p_vs   = (v >= 102) && (v < 104);
    p_fs   = (t == 0);
    if (req) seen = 1;
    if (last && seen) begin sel = !sel; seen = 0; end
    t++;
    if (t == FRAME) begin t = 0; frame++; end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; swap_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_de", de, 0);
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_fstart", frame_start, 0);
      chk("rst_swap_ack", swap_ack, 0);
      chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
      chk("rst_addr", addr, 0);
      chk("rst_disp_sel", disp_sel, 0);
    end
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    for (int n = 0; n < 10000; n++) begin
      mem1[n] = 24'(n);
      mem2[n] = 24'($urandom);
    end
    //             t      chk_addr addr   de hs vs fs
    tbl.push_back('{0,     1, 20'd0,    0, 0, 0, 0});
    tbl.push_back('{1,     1, 20'd1,    1, 0, 0, 1});
    tbl.push_back('{99,    1, 20'd99,   1, 0, 0, 0});
    tbl.push_back('{100,   0, 20'd0,    1, 0, 0, 0});
    tbl.push_back('{101,   0, 20'd0,    0, 0, 0, 0});
    tbl.push_back('{104,   0, 20'd0,    0, 0, 0, 0});
    tbl.push_back('{105,   0, 20'd0,    0, 1, 0, 0});
    tbl.push_back('{112,   0, 20'd0,    0, 1, 0, 0});
    tbl.push_back('{113,   0, 20'd0,    0, 0, 0, 0});
    tbl.push_back('{120,   1, 20'd100,  0, 0, 0, 0});
    tbl.push_back('{121,   1, 20'd101,  1, 0, 0, 0});
    tbl.push_back('{11979, 1, 20'd9999, 1, 0, 0, 0});
    tbl.push_back('{11980, 0, 20'd0,    1, 0, 0, 0});
    tbl.push_back('{12240, 0, 20'd0,    0, 0, 0, 0});
    tbl.push_back('{12241, 0, 20'd0,    0, 0, 1, 0});
    tbl.push_back('{12480, 0, 20'd0,    0, 0, 1, 0});
    tbl.push_back('{12481, 0, 20'd0,    0, 0, 0, 0});

    frame = 0; de_cnt = 0; ack_cnt = 0;
    model_init();
    @(posedge clk); #1;
    do_reset();

    // Frame 0: request only on the boundary cycle -> swap at that boundary.
    for (int k = 0; k < FRAME; k++) cycle(k == FRAME - 1);
    chk("de_per_frame", de_cnt, 10000);
    chk("ack_frame0", ack_cnt, 1);

    // Frame 1: request on cycle 0 plus random absorbed pulses -> one swap at its end.
    de_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < FRAME; k++) cycle(k == 0 || $urandom_range(0, 1999) == 0);
    chk("ack_frame1", ack_cnt, 1);
    chk("de_per_frame1", de_cnt, 10000);

    // Frames 2-3: request held high -> exactly one swap per boundary.
    ack_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) cycle(1'b1);
    chk("ack_held", ack_cnt, 2);

    // Frame 4: pending request, then reset at h=50, v=30.
    ack_cnt = 0;
    for (int k = 0; k < 30 * HT + 50; k++) cycle(k == 100);
    chk("ack_before_reset", ack_cnt, 0);
    do_reset();
    for (int k = 0; k < 300; k++) cycle(1'b0);
    chk("ack_after_reset", ack_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
